// File: rtl/sensor_packet_builder.sv
// Six-channel sensor sample collector that publishes double-buffered 32-byte packets to an SPI slave.
// Optional feature macro: PACKET_CHECKSUM_EN (byte 31 = XOR of bytes 0..30 instead of 8'h00).
module sensor_packet_builder #(
  parameter logic [7:0] HEADER_BYTE = 8'hAA
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic [2:0]         sample_ch,
  input  logic signed [15:0] sample_data,
  input  logic [7:0]         flags,
  output logic [7:0]         data_bytes [0:31],
  output logic               data_ready,
  input  logic               data_ack,
  output logic [7:0]         overrun_count,
  output logic [1:0]         o_dbg_state
);

  // Handshake: data_ready rises when a packet is loaded and stays high, with
  // data_bytes frozen, until the cycle data_ack is seen high in S_WAIT_ACK.
  typedef enum logic [1:0] {
    S_COLLECT  = 2'd0,
    S_PUBLISH  = 2'd1,
    S_WAIT_ACK = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_stage [0:5];
  logic [5:0]  r_mask;
  logic [7:0]  r_seq;
  logic [7:0]  r_overrun;
  logic [7:0]  r_data_bytes [0:31];
  logic        r_data_ready;

  logic        w_accept;
  logic [5:0]  w_sel;
  logic [5:0]  w_mask_base;
  logic [5:0]  w_mask_next;
  logic        w_overwrite;
  logic        w_load;
  logic        w_ack_take;
  logic [7:0]  w_packet [0:31];
  logic [7:0]  w_csum;

  assign w_accept    = sample_valid && (sample_ch < 3'd6);
  assign w_sel       = w_accept ? (6'b000001 << sample_ch) : 6'b000000;
  // The publish edge hands the staged set to data_bytes, so a sample arriving
  // on that edge starts a fresh set rather than counting as an overwrite.
  assign w_mask_base = (r_state == S_PUBLISH) ? 6'h00 : r_mask;
  assign w_mask_next = w_mask_base | w_sel;
  assign w_overwrite = (w_mask_base & w_sel) != 6'h00;

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_ack_take   = 1'b0;
    case (r_state)
      S_COLLECT: begin
        if (w_mask_next == 6'h3F) w_state_next = S_PUBLISH;
      end
      S_PUBLISH: begin
        w_load       = 1'b1;
        w_state_next = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // A set already complete at ack time publishes straight away, leaving
        // exactly one low cycle on data_ready between packets.
        if (data_ack) begin
          w_ack_take   = 1'b1;
          w_state_next = (w_mask_next == 6'h3F) ? S_PUBLISH : S_COLLECT;
        end
      end
      default: w_state_next = S_COLLECT;
    endcase
  end

  always_comb begin
    w_csum = 8'h00;
    for (int i = 0; i < 32; i++) w_packet[i] = 8'h00;
    w_packet[0] = HEADER_BYTE;
    w_packet[1] = r_seq;
    for (int i = 0; i < 6; i++) begin
      w_packet[2 + 2*i] = r_stage[i][15:8];
      w_packet[3 + 2*i] = r_stage[i][7:0];
    end
    w_packet[14] = flags;
    w_packet[15] = r_overrun;
`ifdef PACKET_CHECKSUM_EN
    for (int i = 0; i < 31; i++) w_csum = w_csum ^ w_packet[i];
`endif
    w_packet[31] = w_csum;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_COLLECT;
      r_mask       <= 6'h00;
      r_seq        <= 8'h00;
      r_overrun    <= 8'h00;
      r_data_ready <= 1'b0;
      for (int i = 0; i < 6; i++) r_stage[i] <= 16'h0000;
      for (int i = 0; i < 32; i++) r_data_bytes[i] <= 8'h00;
    end else begin
      r_state <= w_state_next;
      r_mask  <= w_mask_next;
      for (int i = 0; i < 6; i++) begin
        if (w_sel[i]) r_stage[i] <= sample_data;
      end
      if (w_overwrite && (r_overrun != 8'hFF)) r_overrun <= r_overrun + 8'd1;
      if (w_load) begin
        r_data_bytes <= w_packet;
        r_data_ready <= 1'b1;
      end
      if (w_ack_take) begin
        r_data_ready <= 1'b0;
        r_seq        <= r_seq + 8'd1;
      end
    end
  end

  assign data_bytes    = r_data_bytes;
  assign data_ready    = r_data_ready;
  assign overrun_count = r_overrun;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_sensor_packet_builder.sv
// Scoreboard bench for sensor_packet_builder: directed scenarios plus a long randomized run
// against an event-level reference model of staging, sequencing and the ack handshake.
module tb_sensor_packet_builder;

  logic        clk;
  logic        reset;
  logic        sample_valid;
  logic [2:0]  sample_ch;
  logic [15:0] sample_data;
  logic [7:0]  flags;
  logic [7:0]  data_bytes [0:31];
  logic        data_ready;
  logic        data_ack;
  logic [7:0]  overrun_count;
  logic [1:0]  dbg_state;

  sensor_packet_builder dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_ch(sample_ch),
    .sample_data(sample_data), .flags(flags), .data_bytes(data_bytes),
    .data_ready(data_ready), .data_ack(data_ack), .overrun_count(overrun_count),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters and check helper ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0]  m_stage [0:5];
  logic [5:0]   m_mask;
  int           m_ovr;
  logic [7:0]   m_seq;
  bit           m_out;
  longint       m_pub_at;
  longint       cyc_n;
  logic [255:0] exp_q [$];
  logic [255:0] m_cur;
  int           pkt_cnt;

  function automatic logic [255:0] build_pkt(input logic [7:0] fl);
    logic [7:0] b [0:31];
    logic [7:0] x;
    logic [255:0] p;
    for (int i = 0; i < 32; i++) b[i] = 8'h00;
    b[0] = 8'hAA;
    b[1] = m_seq;
    for (int c = 0; c < 6; c++) begin
      b[2 + 2*c] = m_stage[c][15:8];
      b[3 + 2*c] = m_stage[c][7:0];
    end
    b[14] = fl;
    b[15] = 8'(m_ovr);
    x = 8'h00;
`ifdef PACKET_CHECKSUM_EN
    for (int i = 0; i < 31; i++) x = x ^ b[i];
`endif
    b[31] = x;
    for (int i = 0; i < 32; i++) p[255 - 8*i -: 8] = b[i];
    return p;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 6; c++) m_stage[c] = 16'h0000;
    m_mask   = 6'h00;
    m_ovr    = 0;
    m_seq    = 8'h00;
    m_out    = 1'b0;
    m_pub_at = -1;
    pkt_cnt  = 0;
    exp_q.delete();
  endtask

  // One clock edge of the specified behaviour, using the inputs held across the edge.
  task automatic model_edge();
    bit loading;
    bit was_out;
    loading = (m_pub_at == cyc_n);
    was_out = m_out;
    if (loading) begin
      exp_q.push_back(build_pkt(flags));
      m_mask   = 6'h00;
      m_out    = 1'b1;
      m_pub_at = -1;
    end
    if (was_out && data_ack) begin
      m_out = 1'b0;
      m_seq = m_seq + 8'd1;
    end
    if (sample_valid && sample_ch < 3'd6) begin
      if (m_mask[sample_ch]) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
      m_stage[sample_ch] = sample_data;
      m_mask[sample_ch]  = 1'b1;
    end
    if (m_pub_at < 0 && !m_out && m_mask == 6'h3F) m_pub_at = cyc_n + 1;
    cyc_n++;
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input bit v, input logic [2:0] ch, input logic [15:0] d, input bit ack);
    sample_valid = v;
    sample_ch    = ch;
    sample_data  = d;
    data_ack     = ack;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 16'h0000, 1'b0);
  endtask

  task automatic rand_set();
    for (int c = 0; c < 6; c++) cyc(1'b1, 3'(c), 16'($urandom), 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- monitor ----------------
  bit mon_prev = 1'b0;

  initial begin
    logic [255:0] got;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 32; i++) got[255 - 8*i -: 8] = data_bytes[i];
      chk("ready", 256'(data_ready), 256'(m_out));
      chk("overrun", 256'(overrun_count), 256'(m_ovr));
      if (data_ready && !mon_prev) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pkt_pop got=packet_%0h required=no_packet", got);
        end else begin
          m_cur = exp_q.pop_front();
          pkt_cnt++;
          chk("pkt", got, m_cur);
          if (pkt_cnt == 257) chk("seq_wrap_257", 256'(data_bytes[1]), 256'(8'h00));
        end
      end else if (data_ready) begin
        chk("pkt_hold", got, m_cur);
      end
      mon_prev = data_ready;
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] exp28 [0:31];
  logic [7:0] x28;
  longint     cap;

  initial begin
    reset        = 1'b0;
    sample_valid = 1'b0;
    sample_ch    = 3'd0;
    sample_data  = 16'h0000;
    flags        = 8'h00;
    data_ack     = 1'b0;
    cyc_n        = 0;
    model_reset();
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // reset values
    chk("rst_ready", 256'(data_ready), 256'(0));
    chk("rst_overrun", 256'(overrun_count), 256'(0));
    for (int i = 0; i < 32; i++) chk("rst_bytes", 256'(data_bytes[i]), 256'(0));

    // directed known packet and two-edge latency
    flags = 8'h5A;
    for (int i = 0; i < 32; i++) exp28[i] = 8'h00;
    exp28[0] = 8'hAA;
    exp28[14] = 8'h5A;
    for (int i = 0; i < 12; i++) exp28[2 + i] = 8'(i + 1);
    x28 = 8'h00;
`ifdef PACKET_CHECKSUM_EN
    for (int i = 0; i < 31; i++) x28 = x28 ^ exp28[i];
`endif
    exp28[31] = x28;
    for (int c = 0; c < 6; c++) cyc(1'b1, 3'(c), {8'(2*c + 1), 8'(2*c + 2)}, 1'b0);
    chk("lat_edge1", 256'(data_ready), 256'(0));
    idle(1);
    chk("lat_edge2", 256'(data_ready), 256'(1));
    for (int i = 0; i < 32; i++) chk("known_pkt", 256'(data_bytes[i]), 256'(exp28[i]));

    // second set arrives while ack is withheld for 1000 cycles
    flags = 8'h33;
    rand_set();
    idle(1000);
    chk("hold_ready", 256'(data_ready), 256'(1));
    for (int i = 0; i < 32; i++) chk("hold_bytes", 256'(data_bytes[i]), 256'(exp28[i]));
    cyc(1'b0, 3'd0, 16'h0000, 1'b1);
    chk("gap_low", 256'(data_ready), 256'(0));
    idle(1);
    chk("second_ready", 256'(data_ready), 256'(1));
    chk("second_seq", 256'(data_bytes[1]), 256'(1));

    // completing sample coincides with ack
    for (int c = 0; c < 5; c++) cyc(1'b1, 3'(c), 16'($urandom), 1'b0);
    cyc(1'b1, 3'd5, 16'h5A5A, 1'b1);
    chk("same_edge_low", 256'(data_ready), 256'(0));
    idle(2);
    chk("same_edge_seq", 256'(data_bytes[1]), 256'(2));
    cyc(1'b0, 3'd0, 16'h0000, 1'b1);
    cyc(1'b1, 3'd7, 16'hFFFF, 1'b1);
    cyc(1'b1, 3'd6, 16'hFFFF, 1'b0);
    idle(3);

    // overwrite counting and saturation
    do_reset();
    cyc(1'b1, 3'd0, 16'h1111, 1'b0);
    cyc(1'b1, 3'd0, 16'h2222, 1'b0);
    for (int c = 1; c < 6; c++) cyc(1'b1, 3'(c), 16'($urandom), 1'b0);
    idle(2);
    chk("ovr_one", 256'(overrun_count), 256'(1));
    chk("ovr_latest_hi", 256'(data_bytes[2]), 256'(8'h22));
    chk("ovr_pkt_count", 256'(data_bytes[15]), 256'(1));
    cyc(1'b0, 3'd0, 16'h0000, 1'b1);
    for (int i = 0; i < 257; i++) cyc(1'b1, 3'd0, 16'($urandom), 1'b0);
    chk("ovr_sat", 256'(overrun_count), 256'(255));

    // reset while a packet waits for ack
    rand_set();
    idle(2);
    chk("pre_rst_ready", 256'(data_ready), 256'(1));
    #2 reset = 1'b1;
    #1 chk("rst_drop", 256'(data_ready), 256'(0));
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    rand_set();
    idle(2);
    chk("post_rst_seq", 256'(data_bytes[1]), 256'(0));
    chk("post_rst_ovr", 256'(data_bytes[15]), 256'(0));
    cyc(1'b0, 3'd0, 16'h0000, 1'b1);

    // randomized run across sequence wrap, with ignored channels and stray acks
    do_reset();
    cap = 0;
    while (pkt_cnt < 258 && cap < 30000) begin
      flags = 8'($urandom);
      cyc($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
          m_out ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0));
      cap++;
    end
    chk("rand_pkts_seen", 256'(pkt_cnt >= 258), 256'(1));
    idle(3);
    chk("queue_empty", 256'(exp_q.size()), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
